// File: rtl/led_ctrl_pkg.sv
// Shared types and constants for the LED pattern controller.
package led_ctrl_pkg;

  localparam int unsigned LedW = 5;

  typedef enum logic [1:0] {
    ModeIdle   = 2'd0,
    ModeChase  = 2'd1,
    ModeBounce = 2'd2,
    ModeBinary = 2'd3
  } mode_e;

  typedef enum logic {
    DirLeft  = 1'b0,
    DirRight = 1'b1
  } dir_e;

  localparam logic [LedW-1:0] SeedIdle   = 5'b00000;
  localparam logic [LedW-1:0] SeedChase  = 5'b00001;
  localparam logic [LedW-1:0] SeedBounce = 5'b00001;
  localparam logic [LedW-1:0] SeedBinary = 5'b00000;

  // Bounce reverses on reaching either end
  localparam logic [LedW-1:0] LedLeftEnd  = 5'b10000;
  localparam logic [LedW-1:0] LedRightEnd = 5'b00001;

  function automatic mode_e mode_next(mode_e m);
    mode_e r;
    case (m)
      ModeIdle:   r = ModeChase;
      ModeChase:  r = ModeBounce;
      ModeBounce: r = ModeBinary;
      ModeBinary: r = ModeIdle;
      default:    r = ModeIdle;
    endcase
    return r;
  endfunction

  function automatic logic [LedW-1:0] mode_seed(mode_e m);
    logic [LedW-1:0] s;
    case (m)
      ModeIdle:   s = SeedIdle;
      ModeChase:  s = SeedChase;
      ModeBounce: s = SeedBounce;
      ModeBinary: s = SeedBinary;
      default:    s = SeedIdle;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser, plus a stable-level debouncer when
// LED_PATTERN_CTRL_DEBOUNCE_EN is defined. Without the macro the synchronised
// level is passed straight through and DEBOUNCE_CYCLES has no effect.
module btn_debounce
  import led_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 120000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic sync_o,
  output logic level_o
);

  logic [1:0] sync_q;

  // Two-stage synchroniser for the asynchronous button input
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
    end
  end

  assign sync_o = sync_q[1];

`ifdef LED_PATTERN_CTRL_DEBOUNCE_EN
  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;

  // Accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CntLast) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debounce counter and accepted level
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;
`else
  logic unused_debounce_cycles;
  assign unused_debounce_cycles = ^DEBOUNCE_CYCLES;
  assign level_o = sync_q[1];
`endif

endmodule

// File: rtl/led_pattern_ctrl.sv
// Five-LED pattern controller: button-selected mode (idle, chase, bounce,
// binary count), fixed-rate stepping, freeze button and heartbeat LED.
// Button debouncing is enabled by defining LED_PATTERN_CTRL_DEBOUNCE_EN.
module led_pattern_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV        = 1500000,
  parameter int unsigned DEBOUNCE_CYCLES = 120000
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            BTN_NEXT,
  input  logic            BTN_HOLD,
  output logic [LedW-1:0] LED,
  output logic            LEDR_N,
  output logic            LEDG_N,
  output logic [1:0]      MODE
);

  localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);

  logic next_sync, next_lvl;
  logic unused_hold_sync, hold_lvl;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_next (
    .clk_i  (CLK),
    .rst_i  (RST),
    .btn_i  (BTN_NEXT),
    .sync_o (next_sync),
    .level_o(next_lvl)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_hold (
    .clk_i  (CLK),
    .rst_i  (RST),
    .btn_i  (BTN_HOLD),
    .sync_o (unused_hold_sync),
    .level_o(hold_lvl)
  );

  logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
  logic [1:0]       warm_q, warm_d;
  logic             armed_q, armed_d;
  logic             next_prev_q;
  mode_e            mode_q, mode_d;
  logic [LedW-1:0]  led_q, led_d;
  dir_e             dir_q, dir_d;
  logic             green_q, green_d;

  logic            tick, warm_done, next_rise;
  logic [LedW-1:0] shl, shr;

  assign tick      = (tick_cnt_q == TickLast);
  assign warm_done = (warm_q == 2'd2);
  // A button held through reset must be seen released before it can advance the mode
  assign next_rise = next_lvl & ~next_prev_q & armed_q;
  assign shl       = led_q << 1;
  assign shr       = led_q >> 1;

  // Next-state: mode change wins over a coincident tick, which is dropped
  always_comb begin
    mode_d     = mode_q;
    led_d      = led_q;
    dir_d      = dir_q;
    green_d    = green_q;
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    warm_d     = warm_done ? warm_q : warm_q + 2'd1;
    armed_d    = armed_q | (warm_done & ~next_sync & ~next_lvl);

    if (next_rise) begin
      mode_d     = mode_next(mode_q);
      led_d      = mode_seed(mode_d);
      dir_d      = DirLeft;
      tick_cnt_d = '0;
      if (mode_d == ModeIdle) begin
        green_d = 1'b0;
      end
    end else if (tick && !hold_lvl && (mode_q != ModeIdle)) begin
      green_d = ~green_q;
      case (mode_q)
        ModeIdle: ;
        ModeChase: led_d = {led_q[LedW-2:0], led_q[LedW-1]};
        ModeBounce: begin
          if (dir_q == DirLeft) begin
            led_d = shl;
            if (shl == LedLeftEnd) dir_d = DirRight;
          end else begin
            led_d = shr;
            if (shr == LedRightEnd) dir_d = DirLeft;
          end
        end
        ModeBinary: led_d = led_q + 1'b1;
        default: ;
      endcase
    end
  end

  // State registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      tick_cnt_q  <= '0;
      warm_q      <= '0;
      armed_q     <= 1'b0;
      next_prev_q <= 1'b0;
      mode_q      <= ModeIdle;
      led_q       <= SeedIdle;
      dir_q       <= DirLeft;
      green_q     <= 1'b0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      warm_q      <= warm_d;
      armed_q     <= armed_d;
      next_prev_q <= next_lvl;
      mode_q      <= mode_d;
      led_q       <= led_d;
      dir_q       <= dir_d;
      green_q     <= green_d;
    end
  end

  assign LED    = led_q;
  assign MODE   = mode_q;
  assign LEDR_N = ~hold_lvl;
  assign LEDG_N = ~green_q;

endmodule
